// File: rtl/aux_keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: row scan, per-frame debounce with ghost
// rejection, one key code per press over valid/ready, and a 32-bit hex entry register.
module aux_keypad_scanner #(
  parameter int ScanCntMax    = 100000,
  parameter int DebounceScans = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  row_n,
  input  logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ready,
  input  logic        clr,
  output logic [31:0] data,
  output logic        overflow
);

  localparam int CW = (ScanCntMax > 1) ? $clog2(ScanCntMax) : 1;
  localparam int NW = $clog2(DebounceScans + 1);
  localparam logic [CW-1:0] DivLast = CW'(ScanCntMax - 1);
  localparam logic [NW-1:0] DebLast = NW'(DebounceScans);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_HELD} state_t;

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic [1:0]    row_idx;
  logic [3:0]    col_s1, col_s2;
  logic [15:0]   frame_map, frame_now;
  logic          frame_end;
  logic          is_empty, is_single;
  logic [3:0]    hit_idx;
  logic [4:0]    ones;
  state_t        state, state_nxt;
  logic [3:0]    cand, cand_nxt;
  logic [NW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          emit;
  logic          accept;

  assign tick      = (div_cnt == DivLast);
  assign frame_end = tick && (row_idx == 2'd3);
  assign accept    = key_valid && key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      row_idx   <= 2'd0;
      row_n     <= 4'b1110;
      col_s1    <= 4'hF;
      col_s2    <= 4'hF;
      frame_map <= '0;
    end else begin
      col_s1 <= col_n;
      col_s2 <= col_s1;
      if (tick) begin
        div_cnt                        <= '0;
        row_idx                        <= row_idx + 2'd1;
        row_n                          <= {row_n[2:0], row_n[3]};
        frame_map[{row_idx, 2'b00} +: 4] <= ~col_s2;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

  // The last row is still in flight at frame end, so splice it in live.
  always_comb begin
    frame_now        = frame_map;
    frame_now[15:12] = ~col_s2;
    ones             = 5'd0;
    hit_idx          = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (frame_now[i]) begin
        ones    = ones + 5'd1;
        hit_idx = 4'(i);
      end
    end
    is_empty  = (ones == 5'd0);
    is_single = (ones == 5'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cand  <= 4'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MULTI frames fall through the single-key tests, so they never start a press
  // but still count as non-empty while a key is held.
  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    emit      = 1'b0;
    cnt_inc   = cnt + NW'(1);
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (is_single) begin
            cand_nxt = hit_idx;
            cnt_nxt  = NW'(1);
            if (DebounceScans == 1) begin
              emit      = 1'b1;
              state_nxt = S_HELD;
              cnt_nxt   = '0;
            end else begin
              state_nxt = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (is_single && hit_idx == cand) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DebLast) begin
              emit      = 1'b1;
              state_nxt = S_HELD;
              cnt_nxt   = '0;
            end
          end else if (is_single) begin
            cand_nxt = hit_idx;
            cnt_nxt  = NW'(1);
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_HELD: begin
          if (is_empty) begin
            cnt_nxt = cnt_inc;
            if (cnt_inc == DebLast) begin
              state_nxt = S_IDLE;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      overflow  <= 1'b0;
      data      <= '0;
    end else begin
      if (emit) begin
        if (!key_valid || accept) begin
          key_code  <= cand_nxt;
          key_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (accept) begin
        key_valid <= 1'b0;
      end
      if (clr) begin
        data <= '0;
      end else if (accept) begin
        data <= {data[27:0], key_code};
      end
    end
  end

endmodule

// File: tb/tb_aux_keypad_scanner.sv
// Bench for aux_keypad_scanner: emulates a physical keypad and checks every frame
// against a frame-level debounce and handshake reference model.
module tb_aux_keypad_scanner;

  localparam int Scan = 4;
  localparam int Deb  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] data;
  logic        overflow;

  logic [15:0] pressed = 16'h0000;

  int total = 0;
  int bad   = 0;

  bit          m_valid;
  logic [3:0]  m_code;
  bit          m_ovf;
  logic [31:0] m_data;
  bit          locked;
  logic [3:0]  streak_key;
  int          streak;
  int          quiet;

  logic [15:0] cur;
  int          sel, acc_c, clr_c;

  aux_keypad_scanner #(.ScanCntMax(Scan), .DebounceScans(Deb)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .clr(clr), .data(data), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its column to whichever row is driven low.
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row_n[r] && pressed[r*4+c]) col_n[c] = 1'b0;
      end
    end
  end

  function automatic logic [15:0] kbit(input int k);
    kbit = 16'(1) << k;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_valid = 0; m_code = 4'd0; m_ovf = 0; m_data = 32'd0;
    locked = 0; streak_key = 4'd0; streak = 0; quiet = 0;
  endtask

  // A key is accepted after Deb consecutive single-key frames of the same key,
  // and re-armed after Deb consecutive empty frames.
  task automatic frameModel(input logic [15:0] keys, output bit em, output logic [3:0] code);
    int n;
    int idx;
    n = $countones(keys);
    em = 0;
    code = 4'd0;
    idx = 0;
    for (int k = 0; k < 16; k++) if (keys[k]) idx = k;
    if (!locked) begin
      if (n == 1) begin
        if (streak > 0 && streak_key == 4'(idx)) streak++;
        else begin
          streak_key = 4'(idx);
          streak = 1;
        end
      end else begin
        streak = 0;
      end
      if (streak == Deb) begin
        em = 1; code = streak_key; locked = 1; quiet = 0; streak = 0;
      end
    end else begin
      if (n == 0) quiet++;
      else quiet = 0;
      if (quiet == Deb) begin
        locked = 0; quiet = 0;
      end
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_row_n", 32'(row_n), 32'hE);
    checkOutput("rst_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_data", data, 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Runs one whole frame (starting at a negedge on a frame boundary) with the
  // given key set; acc/clr select the cycle for a one-cycle pulse, -1 for none.
  task automatic applyStimulus(input logic [15:0] keys, input int acc_cyc, input int clr_cyc);
    bit         em;
    bit         acc;
    logic [3:0] code;
    logic [3:0] exp_row;
    pressed = keys;
    frameModel(keys, em, code);
    for (int i = 0; i < 16; i++) begin
      key_ready = (i == acc_cyc);
      clr       = (i == clr_cyc);
      acc = key_ready && m_valid;
      if (clr) m_data = 32'd0;
      else if (acc) m_data = {m_data[27:0], m_code};
      if (em && i == 15) begin
        if (!m_valid || acc) begin
          m_code = code;
          m_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (acc) begin
        m_valid = 0;
      end
      @(posedge clk);
      @(negedge clk);
      exp_row = ~(4'b0001 << (((i + 1) / 4) % 4));
      checkOutput("row_n", 32'(row_n), 32'(exp_row));
      checkOutput("valid_cyc", 32'(key_valid), 32'(m_valid));
    end
    key_ready = 1'b0;
    clr = 1'b0;
    checkOutput("frame_code", 32'(key_code), 32'(m_code));
    checkOutput("frame_ovf", 32'(overflow), 32'(m_ovf));
    checkOutput("frame_data", data, m_data);
  endtask

  task automatic pressRelease(input int k, input int acc_cyc);
    applyStimulus(kbit(k), -1, -1);
    applyStimulus(kbit(k), -1, -1);
    applyStimulus(16'h0, acc_cyc, -1);
    applyStimulus(16'h0, -1, -1);
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    doReset();
    applyStimulus(16'h0, -1, -1);
    repeat (6) @(negedge clk);
    doReset();
    applyStimulus(16'h0, -1, -1);

    // single press of key 9, then accept
    applyStimulus(kbit(9), -1, -1);
    applyStimulus(kbit(9), -1, -1);
    checkOutput("press_valid", 32'(key_valid), 32'd1);
    checkOutput("press_code", 32'(key_code), 32'd9);
    applyStimulus(kbit(9), 3, -1);
    checkOutput("accept_data", data, 32'h9);
    checkOutput("accept_valid", 32'(key_valid), 32'd0);
    applyStimulus(16'h0, -1, -1);
    applyStimulus(16'h0, -1, -1);

    // emit coinciding with accept loads the new key without overflow
    pressRelease(2, -1);
    applyStimulus(kbit(10), -1, -1);
    applyStimulus(kbit(10), 15, -1);
    checkOutput("coinc_valid", 32'(key_valid), 32'd1);
    checkOutput("coinc_code", 32'(key_code), 32'd10);
    checkOutput("coinc_ovf", 32'(overflow), 32'd0);
    applyStimulus(16'h0, 0, -1);
    applyStimulus(16'h0, -1, -1);
    checkOutput("coinc_data", data, 32'h92A);

    // bounce: key 5 only in alternate frames
    for (int f = 0; f < 6; f++) applyStimulus((f % 2 == 0) ? kbit(5) : 16'h0, -1, -1);
    checkOutput("bounce_valid", 32'(key_valid), 32'd0);

    // ghosting: keys 0 and 15 together
    for (int f = 0; f < 4; f++) applyStimulus(kbit(0) | kbit(15), -1, -1);
    checkOutput("ghost_valid", 32'(key_valid), 32'd0);
    checkOutput("ghost_ovf", 32'(overflow), 32'd0);
    applyStimulus(16'h0, -1, 1);
    applyStimulus(16'h0, -1, -1);

    // entry register 1,2,3 then clr wins over accept of 4
    pressRelease(1, 3);
    pressRelease(2, 3);
    pressRelease(3, 3);
    checkOutput("entry_123", data, 32'h123);
    applyStimulus(kbit(4), -1, -1);
    applyStimulus(kbit(4), -1, -1);
    applyStimulus(16'h0, 3, 3);
    applyStimulus(16'h0, -1, -1);
    checkOutput("clr_data", data, 32'h0);
    checkOutput("clr_valid", 32'(key_valid), 32'd0);

    // overflow: second key dropped while first unconsumed
    pressRelease(3, -1);
    pressRelease(7, -1);
    checkOutput("ovf_code", 32'(key_code), 32'd3);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);

    // holding a key for 20 frames yields a single event
    applyStimulus(16'h0, 0, 0);
    for (int f = 0; f < 20; f++) applyStimulus(kbit(3), 2, -1);
    applyStimulus(16'h0, 2, -1);
    applyStimulus(16'h0, -1, -1);
    checkOutput("repeat_data", data, 32'h3);

    // reset while held: key 6 detected afresh
    applyStimulus(kbit(6), -1, -1);
    applyStimulus(kbit(6), -1, -1);
    applyStimulus(kbit(6), 1, -1);
    repeat (5) @(negedge clk);
    doReset();
    applyStimulus(kbit(6), -1, -1);
    checkOutput("rheld_early", 32'(key_valid), 32'd0);
    applyStimulus(kbit(6), -1, -1);
    checkOutput("rheld_valid", 32'(key_valid), 32'd1);
    checkOutput("rheld_code", 32'(key_code), 32'd6);
    checkOutput("rheld_ovf", 32'(overflow), 32'd0);
    applyStimulus(16'h0, 4, -1);
    applyStimulus(16'h0, -1, -1);

    // randomized frames
    cur = 16'h0;
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        sel = int'($urandom_range(0, 9));
        if (sel < 4) cur = 16'h0;
        else if (sel < 8) cur = kbit(int'($urandom_range(0, 3)));
        else cur = kbit(int'($urandom_range(0, 15))) | kbit(int'($urandom_range(0, 15)));
      end
      acc_c = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
      clr_c = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 15)) : -1;
      applyStimulus(cur, acc_c, clr_c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aux_keypad_scanner.md
# aux_keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces it, and delivers one hex key code per press over a valid/ready handshake. Accepted digits are shifted into a 32-bit entry register whose value is sized to drive the board's eight-digit hex display directly. It is the user-input counterpart of the multiplexed display path and reuses the same scan-tick structure: a free-running divider steps a one-hot, active-low select bus.

## Interface
- ScanCntMax, 100000: clk cycles per row dwell, which is 1 kHz at 100 MHz. Minimum 2.
- DebounceScans, 4: consecutive identical full-matrix frames required to accept a press or a release. Minimum 1.

- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- row_n  out  4  active-low row drive, one-hot low
- col_n  in  4  active-low column sense, externally pulled up, asynchronous
- key_valid  out  1  key_code holds an unconsumed key
- key_code  out  4  key code = row*4 + col; stable while key_valid is high
- key_ready  in  1  consumer accepts when key_valid && key_ready
- clr  in  1  synchronous clear of data
- data  out  32  entry register; the newest digit is in data[3:0]
- overflow  out  1  sticky; set when a key event is dropped; cleared only by reset

## Operation
- **Divider:** counts 0..ScanCntMax-1 and pulses tick for one cycle at ScanCntMax-1, then wraps to 0.
- **Row index:** a 2-bit row index r advances on each tick (3 wraps to 0). row_n = ~(4'b1 << r).
- **Column sync:** col_n passes through a 2-flop synchronizer.
- **Sampling:** on tick, before r advances, the inverted synchronized columns are written into frame map bits [r*4 +: 4].
- **Frame end:** the tick with r==3 completes a frame. The frame is classified as:
  - EMPTY: no bit set.
  - SINGLE(k): exactly one bit k set.
  - MULTI: two or more bits set. MULTI is treated as EMPTY for press detection (ghosting rejection) and as non-empty for release detection.
- **Debounce FSM.** It is evaluated only at frame end and holds a candidate code cand and a counter cnt.
  - IDLE: on SINGLE(k), set cand=k and cnt=1, then go to CHECK. If DebounceScans==1, emit immediately and go to HELD.
  - CHECK:
    - SINGLE(cand): cnt++. When cnt reaches DebounceScans, emit and go to HELD.
    - SINGLE(j≠cand): restart with cand=j, cnt=1.
    - EMPTY or MULTI: go to IDLE.
  - HELD:
    - EMPTY: cnt++. When cnt reaches DebounceScans, go to IDLE.
    - Any non-empty frame: cnt=0.
    - cnt is cleared on entry to HELD.
    - Pressing a different key while held produces no event until a full release is seen.
- **Emit:**
  - If key_valid is low: key_code<=cand and key_valid<=1 on the next edge.
  - If key_valid is already high: the event is dropped, overflow<=1, and key_code is unchanged.
- **Handshake:**
  - On key_valid && key_ready, key_valid<=0.
  - In the same cycle, data <= {data[27:0], key_code}.
  - If emit and accept coincide on one edge, the new key is loaded: key_valid stays 1, key_code takes the new value, and there is no overflow.
- **clr:** data<=0. If clr coincides with an accept, clr wins: the digit is consumed, key_valid drops, and data becomes 0.
- **Reset mid-operation:** every element returns to its reset value immediately, whatever the FSM state. A key still held at reset release is detected as a fresh press.

## Timing
- **Reset values:** row_n=4'b1110, key_valid=0, key_code=0, data=0, overflow=0, FSM=IDLE, divider=0, frame map=0, synchronizer=all-released.
- **Settling:** each row dwells ScanCntMax cycles before its columns are sampled. This hides the 2-cycle synchronizer and board settling.
- **Frame period:** 4*ScanCntMax cycles.
- **Press latency:** for a key stable across whole frames, key_valid rises 1 cycle after the frame-end tick of the DebounceScans-th frame.
- **Release latency:** DebounceScans EMPTY frames after the last non-empty frame.
- **Throughput:** at most one key per press/release cycle. key_valid is level-held indefinitely until accepted.
- **Outputs:** all outputs are registered, with no combinational path from key_ready or clr to any output.

## Test plan
All runs use ScanCntMax=4 and DebounceScans=2, so one frame is 16 cycles.
- **Reset:** assert rst_n=0 mid-scan. Required: row_n=1110, key_valid=0, data=0, overflow=0 asynchronously. After release, row_n steps through 1101, 1011, 0111 every 4 cycles.
- **Single press:** hold row 2 / col 1 (col_n=1101 while row_n=1011) from a frame boundary, with key_ready=0. Required: key_valid=1 and key_code=9 one cycle after the 2nd frame end. Raising key_ready then gives data=0x00000009 and key_valid=0.
- **Bounce and ghosting:**
  - Key 5 present only in alternate frames: no key_valid.
  - Keys 0 and 15 held together: no key_valid and no overflow.
- **Overflow and auto-repeat:**
  - key_ready=0; press/release key 3, then key 7. Required: key_code stays 3, overflow=1.
  - Holding key 3 for 20 frames gives exactly one event.
- **Entry register:** accept keys 1,2,3 giving data=0x00000123. Then assert clr in the same cycle as the accept of key 4. Required: data=0 and key_valid=0.
- **Reset while held:** rst_n pulse during HELD with key 6 still pressed. Required: a new key 6 event 2 frames after reset release.
